// File: rtl/hd44780_nybble_sequencer.sv
// HD44780 4-bit bus sequencer: runs the power-on 4-bit init sequence, then
// sends each accepted byte as two nybbles with E pulses and a post-command
// wait. Every delay is delegated to an external state timer via
// tmr_len/tmr_start/tmr_end.
module hd44780_nybble_sequencer #(
    parameter int TIMER_BITS  = 20,
    parameter int DLY_POWERUP = 720000,
    parameter int DLY_4100US  = 196800,
    parameter int DLY_100US   = 4800,
    parameter int DLY_40US    = 1920,
    parameter int DLY_1640US  = 78720,
    parameter int DLY_E       = 24
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  STB_I,
    input  logic [7:0]            DAT_I,
    input  logic                  RS_I,
    output logic                  ready_o,
    output logic                  ACK_O,
    output logic                  init_done_o,
    output logic                  lcd_rs,
    output logic                  lcd_e,
    output logic [3:0]            lcd_data,
    output logic [TIMER_BITS-1:0] tmr_len,
    output logic                  tmr_start,
    input  logic                  tmr_end
);

    localparam logic [TIMER_BITS-1:0] LEN_POWERUP = TIMER_BITS'(DLY_POWERUP);
    localparam logic [TIMER_BITS-1:0] LEN_4100US  = TIMER_BITS'(DLY_4100US);
    localparam logic [TIMER_BITS-1:0] LEN_100US   = TIMER_BITS'(DLY_100US);
    localparam logic [TIMER_BITS-1:0] LEN_40US    = TIMER_BITS'(DLY_40US);
    localparam logic [TIMER_BITS-1:0] LEN_1640US  = TIMER_BITS'(DLY_1640US);
    localparam logic [TIMER_BITS-1:0] LEN_E       = TIMER_BITS'(DLY_E);

    typedef enum logic [2:0] {
        S_RESET,
        S_PWRWAIT,
        S_INIT,
        S_IDLE,
        S_NYB_SETUP,
        S_NYB_EHI,
        S_NYB_ELO,
        S_POSTWAIT
    } state_t;

    state_t     state;
    logic [1:0] step;         // init nybble index 0..3
    logic       in_init;      // nybbles currently belong to the init sequence
    logic       low_pending;  // high nybble on the bus, low nybble still to send
    logic [7:0] dat_q;
    logic       rs_q;
    logic       timer_done;

    // Post-wait after each init nybble: 4.1 ms, 100 us, 100 us, 40 us.
    function automatic logic [TIMER_BITS-1:0] init_post_len(input logic [1:0] idx);
        case (idx)
            2'd0:    return LEN_4100US;
            2'd1:    return LEN_100US;
            2'd2:    return LEN_100US;
            default: return LEN_40US;
        endcase
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic [TIMER_BITS-1:0] byte_post_len(input logic rs,
                                                            input logic [7:0] dat);
        if (!rs && (dat == 8'h01 || dat == 8'h02 || dat == 8'h03))
            return LEN_1640US;
        return LEN_40US;
    endfunction

    // An end strobe in the same cycle as our start pulse cannot belong to the
    // wait being launched, so it is not taken as completion.
    assign timer_done = tmr_end && !tmr_start;

    // Sequencer FSM; all outputs registered, one-cycle strobes default low.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state       <= S_RESET;
            step        <= 2'd0;
            in_init     <= 1'b1;
            low_pending <= 1'b0;
            ready_o     <= 1'b0;
            ACK_O       <= 1'b0;
            init_done_o <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_e       <= 1'b0;
            lcd_data    <= 4'h0;
            tmr_len     <= '0;
            tmr_start   <= 1'b0;
        end else begin
            tmr_start <= 1'b0;
            ACK_O     <= 1'b0;
            case (state)
                S_RESET: begin
                    tmr_len   <= LEN_POWERUP;
                    tmr_start <= 1'b1;
                    state     <= S_PWRWAIT;
                end
                S_PWRWAIT: begin
                    if (timer_done) begin
                        step  <= 2'd0;
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    lcd_rs      <= 1'b0;
                    lcd_data    <= (step == 2'd3) ? 4'h2 : 4'h3;
                    low_pending <= 1'b0;
                    tmr_len     <= LEN_E;
                    tmr_start   <= 1'b1;
                    state       <= S_NYB_SETUP;
                end
                S_IDLE: begin
                    if (STB_I) begin
                        dat_q       <= DAT_I;
                        rs_q        <= RS_I;
                        ready_o     <= 1'b0;
                        lcd_rs      <= RS_I;
                        lcd_data    <= DAT_I[7:4];
                        low_pending <= 1'b1;
                        tmr_len     <= LEN_E;
                        tmr_start   <= 1'b1;
                        state       <= S_NYB_SETUP;
                    end
                end
                S_NYB_SETUP: begin
                    if (timer_done) begin
                        lcd_e     <= 1'b1;
                        tmr_len   <= LEN_E;
                        tmr_start <= 1'b1;
                        state     <= S_NYB_EHI;
                    end
                end
                S_NYB_EHI: begin
                    if (timer_done) begin
                        lcd_e     <= 1'b0;
                        tmr_len   <= LEN_E;
                        tmr_start <= 1'b1;
                        state     <= S_NYB_ELO;
                    end
                end
                S_NYB_ELO: begin
                    if (timer_done) begin
                        tmr_start <= 1'b1;
                        if (low_pending) begin
                            lcd_data    <= dat_q[3:0];
                            low_pending <= 1'b0;
                            tmr_len     <= LEN_E;
                            state       <= S_NYB_SETUP;
                        end else begin
                            tmr_len <= in_init ? init_post_len(step)
                                               : byte_post_len(rs_q, dat_q);
                            state   <= S_POSTWAIT;
                        end
                    end
                end
                S_POSTWAIT: begin
                    if (timer_done) begin
                        if (!in_init) begin
                            ACK_O   <= 1'b1;
                            ready_o <= 1'b1;
                            state   <= S_IDLE;
                        end else if (step == 2'd3) begin
                            in_init     <= 1'b0;
                            init_done_o <= 1'b1;
                            ready_o     <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            step  <= step + 2'd1;
                            state <= S_INIT;
                        end
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule
